nlms_engine: RTL and testbench

- Parametrised, resource-shared successor to the team's fixed 64-tap NLMS weight-update block.
- Computes the normalised step term = (error << DIV_FRAC) / norm with an internal serial divider, so no vendor IP is needed.
- Updates the coefficients LANES at a time, with saturating accumulators and optional leakage.
- Sits between the ANC error/energy path and the adaptive FIR, which reads coeffs_out.

---
 rtl/nlms_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_nlms_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlms_engine.sv
// nlms_engine: resource-shared NLMS coefficient update. A serial restoring
// divider forms the step term, then LANES saturating accumulators update per cycle.
module nlms_engine #(
    parameter int TAPS       = 64,
    parameter int LANES      = 4,
    parameter int SAMPLE_W   = 16,
    parameter int ERR_W      = 16,
    parameter int NORM_W     = 32,
    parameter int DIV_FRAC   = 8,
    parameter int ACC_W      = 35,
    parameter int COEFF_W    = 10,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [ERR_W-1:0]         error_in,
    input  logic [NORM_W-1:0]        norm_in,
    input  logic [$clog2(TAPS)-1:0]  offset_in,
    input  logic                     leak_en_in,
    input  logic                     clear_in,
    input  logic [TAPS*SAMPLE_W-1:0] sample_in,
    output logic [TAPS*COEFF_W-1:0]  coeffs_out,
    output logic                     done_out,
    output logic                     div0_out
);

    localparam int Q_W    = ERR_W + DIV_FRAC;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int NGRP   = TAPS / LANES;
    localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int DCNT_W = $clog2(Q_W + 1);
    localparam int PROD_W = Q_W + SAMPLE_W;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 2;
    localparam int TOP_W  = SUM_W - ACC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      accept_s;
    logic                      norm_bad_s;
    logic [Q_W-1:0]            dvd_ext_s;
    logic [Q_W-1:0]            dvd_mag_s;
    logic [NORM_W:0]           trial_s;
    logic                      trial_ge_s;
    logic signed [Q_W-1:0]     term_s;

    logic                      err_neg_r;
    logic [NORM_W-1:0]         divisor_r;
    logic [NORM_W-1:0]         rem_r;
    logic [Q_W-1:0]            quo_r;
    logic [DCNT_W-1:0]         dcnt_r;
    logic [GRP_W-1:0]          grp_r;
    logic [TAP_W-1:0]          offset_r;
    logic                      leak_r;
    logic                      div0_r;
    logic signed [ACC_W-1:0]   acc_r [TAPS];

    logic signed [SAMPLE_W-1:0] samp_arr_s [TAPS];
    logic [TAP_W-1:0]           lane_k_s   [LANES];
    logic [TAP_W-1:0]           lane_sidx_s[LANES];
    logic signed [ACC_W-1:0]    lane_acc_s [LANES];
    logic signed [ACC_W-1:0]    lane_leak_s[LANES];
    logic [PROD_W-1:0]          lane_prod_s[LANES];
    logic [SUM_W-1:0]           lane_sum_s [LANES];
    logic signed [ACC_W-1:0]    lane_next_s[LANES];

    // Clamp a full-width sum into the signed accumulator range instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [SUM_W-1:0] v);
        logic [TOP_W-1:0] top;
        top = v[SUM_W-1:ACC_W-1];
        if ((top == {TOP_W{1'b0}}) || (top == {TOP_W{1'b1}})) begin
            sat_acc = v[ACC_W-1:0];
        end else if (v[SUM_W-1]) begin
            sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
        end
    endfunction

    genvar gj;
    generate
        for (gj = 0; gj < TAPS; gj++) begin : g_tap
            assign samp_arr_s[gj] = sample_in[gj*SAMPLE_W +: SAMPLE_W];
            assign coeffs_out[gj*COEFF_W +: COEFF_W] = acc_r[gj][ACC_W-1 -: COEFF_W];
        end
    endgenerate

    assign accept_s   = valid_in && (state_r == ST_IDLE);
    assign norm_bad_s = norm_in[NORM_W-1] || (norm_in == {NORM_W{1'b0}});
    assign dvd_ext_s  = {error_in, {DIV_FRAC{1'b0}}};
    assign dvd_mag_s  = error_in[ERR_W-1] ? ({Q_W{1'b0}} - dvd_ext_s) : dvd_ext_s;
    assign trial_s    = {rem_r, quo_r[Q_W-1]};
    assign trial_ge_s = (trial_s >= {1'b0, divisor_r});

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = norm_bad_s ? ST_DONE : ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (dcnt_r == DCNT_W'(Q_W - 1)) begin
                    state_nxt_s = ST_UPD;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_UPD: begin
                if (grp_r == GRP_W'(NGRP - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_UPD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        ready_out = 1'b0;
        done_out  = 1'b0;
        div0_out  = 1'b0;
        case (state_r)
            ST_IDLE: ready_out = 1'b1;
            ST_DONE: begin
                done_out = 1'b1;
                div0_out = div0_r;
            end
            default: ready_out = 1'b0;
        endcase
    end

    // Signed step term from the quotient magnitude, clamped to the Q_W range.
    always_comb begin
        term_s = $signed(quo_r);
        if (err_neg_r) begin
            if (quo_r[Q_W-1] && (quo_r[Q_W-2:0] != {(Q_W-1){1'b0}})) begin
                term_s = $signed({1'b1, {(Q_W-1){1'b0}}});
            end else begin
                term_s = $signed({Q_W{1'b0}} - quo_r);
            end
        end else begin
            if (quo_r[Q_W-1]) begin
                term_s = $signed({1'b0, {(Q_W-1){1'b1}}});
            end else begin
                term_s = $signed(quo_r);
            end
        end
    end

    // Per-lane update: newest sample pairs with tap 0, walking backwards with wrap.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_k_s[l]    = TAP_W'(int'(grp_r) * LANES + l);
            lane_sidx_s[l] = offset_r - lane_k_s[l];
            lane_acc_s[l]  = acc_r[lane_k_s[l]];
            if (leak_r) begin
                lane_leak_s[l] = lane_acc_s[l] >>> LEAK_SHIFT;
            end else begin
                lane_leak_s[l] = {ACC_W{1'b0}};
            end
            lane_prod_s[l] = {{SAMPLE_W{term_s[Q_W-1]}}, term_s}
                           * {{Q_W{samp_arr_s[lane_sidx_s[l]][SAMPLE_W-1]}}, samp_arr_s[lane_sidx_s[l]]};
            lane_sum_s[l]  = {{(SUM_W-ACC_W){lane_acc_s[l][ACC_W-1]}}, lane_acc_s[l]}
                           - {{(SUM_W-ACC_W){lane_leak_s[l][ACC_W-1]}}, lane_leak_s[l]}
                           + {{(SUM_W-PROD_W){lane_prod_s[l][PROD_W-1]}}, lane_prod_s[l]};
            lane_next_s[l] = sat_acc(lane_sum_s[l]);
        end
    end

    // Request capture, serial divider and accumulator bank.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            err_neg_r <= 1'b0;
            divisor_r <= {NORM_W{1'b0}};
            rem_r     <= {NORM_W{1'b0}};
            quo_r     <= {Q_W{1'b0}};
            dcnt_r    <= {DCNT_W{1'b0}};
            grp_r     <= {GRP_W{1'b0}};
            offset_r  <= {TAP_W{1'b0}};
            leak_r    <= 1'b0;
            div0_r    <= 1'b0;
            for (int j = 0; j < TAPS; j++) begin
                acc_r[j] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_in) begin
                        for (int j = 0; j < TAPS; j++) begin
                            acc_r[j] <= {ACC_W{1'b0}};
                        end
                    end
                    if (accept_s) begin
                        err_neg_r <= error_in[ERR_W-1];
                        divisor_r <= norm_in;
                        rem_r     <= {NORM_W{1'b0}};
                        quo_r     <= dvd_mag_s;
                        dcnt_r    <= {DCNT_W{1'b0}};
                        grp_r     <= {GRP_W{1'b0}};
                        offset_r  <= offset_in;
                        leak_r    <= leak_en_in;
                        div0_r    <= norm_bad_s;
                    end
                end
                ST_DIV: begin
                    // Dividend bits shift out of quo_r's top as quotient bits enter at the bottom.
                    if (trial_ge_s) begin
                        rem_r <= NORM_W'(trial_s - {1'b0, divisor_r});
                        quo_r <= {quo_r[Q_W-2:0], 1'b1};
                    end else begin
                        rem_r <= trial_s[NORM_W-1:0];
                        quo_r <= {quo_r[Q_W-2:0], 1'b0};
                    end
                    dcnt_r <= dcnt_r + DCNT_W'(1);
                end
                ST_UPD: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_r[lane_k_s[l]] <= lane_next_s[l];
                    end
                    grp_r <= grp_r + GRP_W'(1);
                end
                ST_DONE: div0_r <= div0_r;
                default: div0_r <= div0_r;
            endcase
        end
    end

endmodule

// File: tb/tb_nlms_engine.sv
// Self-checking bench for nlms_engine: directed vector table, hand-written
// multi-cycle sequences, and randomized requests against a behavioural model.
module tb_nlms_engine;

    localparam int TAPS     = 64;
    localparam int SAMPLE_W = 16;
    localparam int ERR_W    = 16;
    localparam int NORM_W   = 32;
    localparam int COEFF_W  = 10;
    localparam int NORM_LAT = 41;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     valid_in;
    logic                     ready_out;
    logic [ERR_W-1:0]         error_in;
    logic [NORM_W-1:0]        norm_in;
    logic [5:0]               offset_in;
    logic                     leak_en_in;
    logic                     clear_in;
    logic [TAPS*SAMPLE_W-1:0] sample_in;
    logic [TAPS*COEFF_W-1:0]  coeffs_out;
    logic                     done_out;
    logic                     div0_out;

    int     checks = 0;
    int     errors = 0;
    int     samp  [TAPS];
    longint m_acc [TAPS];

    nlms_engine dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .error_in   (error_in),
        .norm_in    (norm_in),
        .offset_in  (offset_in),
        .leak_en_in (leak_en_in),
        .clear_in   (clear_in),
        .sample_in  (sample_in),
        .coeffs_out (coeffs_out),
        .done_out   (done_out),
        .div0_out   (div0_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string name;
        bit    rst;
        int    err;
        int    norm;
        int    off;
        bit    leak;
        int    fill;
        int    spot;
        int    spot_val;
        int    lat;
        bit    div0;
        int    exp_all;
        int    exp_k;
        int    exp_kval;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_coeff(input int k);
        logic [COEFF_W-1:0] c;
        c = coeffs_out[k*COEFF_W +: COEFF_W];
        return int'($signed(c));
    endfunction

    task automatic apply_samples();
        for (int j = 0; j < TAPS; j++) sample_in[j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(samp[j]);
    endtask

    task automatic fill_samples(input int fill, input int spot, input int spot_val);
        for (int j = 0; j < TAPS; j++) samp[j] = fill;
        if (spot >= 0) samp[spot] = spot_val;
        apply_samples();
    endtask

    // Reference: term = (error*2^8)/norm truncated, then acc = sat(acc - leak + term*s).
    task automatic model_update(input int err, input int norm, input int off, input bit leak, input bit clr);
        longint q, p, lk, v;
        longint amax, amin;
        amax = (longint'(1) << 34) - 1;
        amin = -(longint'(1) << 34);
        if (clr) for (int k = 0; k < TAPS; k++) m_acc[k] = 0;
        if (norm <= 0) return;
        q = (longint'(err) * 256) / longint'(norm);
        if (q > 8388607) q = 8388607;
        if (q < -8388608) q = -8388608;
        for (int k = 0; k < TAPS; k++) begin
            p  = q * longint'(samp[(off - k + TAPS) % TAPS]);
            lk = leak ? (m_acc[k] >>> 8) : 0;
            v  = m_acc[k] - lk + p;
            if (v > amax) v = amax;
            if (v < amin) v = amin;
            m_acc[k] = v;
        end
    endtask

    task automatic check_all(input string name, input int val, input int k_sp, input int val_sp);
        int bad, e;
        bad = -1;
        for (int k = 0; k < TAPS; k++) begin
            e = (k == k_sp) ? val_sp : val;
            if (get_coeff(k) != e && bad < 0) bad = k;
        end
        if (bad < 0) bad = (k_sp >= 0) ? k_sp : 0;
        check(name, get_coeff(bad), (bad == k_sp) ? val_sp : val);
    endtask

    task automatic check_model(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < TAPS; k++)
            if (get_coeff(k) != int'(m_acc[k] >>> 25) && bad < 0) bad = k;
        if (bad < 0) bad = 0;
        check(name, get_coeff(bad), m_acc[bad] >>> 25);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0; valid_in = 1'b0; clear_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < TAPS; k++) m_acc[k] = 0;
    endtask

    // Issue one request and watch a bounded window for done_out.
    task automatic run_req(input int err, input int norm, input int off, input bit leak, input bit clr,
                           output int lat, output int d0, output int dones, output int rdy_after);
        @(negedge clk_in);
        error_in = ERR_W'(err); norm_in = NORM_W'(norm); offset_in = 6'(off);
        leak_en_in = leak; clear_in = clr; valid_in = 1'b1;
        @(posedge clk_in);
        lat = -1; d0 = 0; dones = 0; rdy_after = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_in);
            if (i == 1) begin valid_in = 1'b0; clear_in = 1'b0; end
            if (lat > 0 && i == lat + 1) rdy_after = int'(ready_out);
            if (done_out) begin
                dones++;
                if (lat < 0) begin lat = i; d0 = int'(div0_out); end
            end
        end
        model_update(err, norm, off, leak, clr);
    endtask

    vec_t vt [12];

    initial begin
        int lat, d0, dones, rdy, acc_cnt, first_acc, second_acc;
        int err, norm, off, mode;
        bit leak, clr;

        vt[0]  = '{"uniform",      1,  16384,  1, 0, 0,     8, -1, 0, NORM_LAT, 0,    1, -1, 0};
        vt[1]  = '{"index_off5",   1,  16384,  1, 5, 0,     0,  3, 8, NORM_LAT, 0,    0,  2, 1};
        vt[2]  = '{"index_wrap",   1,  16384,  1, 1, 0,     0,  3, 8, NORM_LAT, 0,    0, 62, 1};
        vt[3]  = '{"sat_pos",      1,  16384,  1, 0, 0, 32767, -1, 0, NORM_LAT, 0,  511, -1, 0};
        vt[4]  = '{"sat_neg1",     0, -16384,  1, 0, 0, 32767, -1, 0, NORM_LAT, 0, -512, -1, 0};
        vt[5]  = '{"sat_neg2",     0, -16384,  1, 0, 0, 32767, -1, 0, NORM_LAT, 0, -512, -1, 0};
        vt[6]  = '{"sat_neg3",     0, -16384,  1, 0, 0, 32767, -1, 0, NORM_LAT, 0, -512, -1, 0};
        vt[7]  = '{"norm_zero",    0,  16384,  0, 0, 0, 32767, -1, 0, 1,        1, -512, -1, 0};
        vt[8]  = '{"norm_neg",     0,  16384, -5, 0, 0, 32767, -1, 0, 1,        1, -512, -1, 0};
        vt[9]  = '{"uniform2",     1,  16384,  1, 0, 0,     8, -1, 0, NORM_LAT, 0,    1, -1, 0};
        vt[10] = '{"leak",         0,      0,  1, 0, 1,     8, -1, 0, NORM_LAT, 0,    0, -1, 0};
        vt[11] = '{"after_leak",   0,  16384,  1, 0, 0,     8, -1, 0, NORM_LAT, 0,    1, -1, 0};

        rst_n_in = 1'b0; valid_in = 1'b0; clear_in = 1'b0; leak_en_in = 1'b0;
        error_in = '0; norm_in = '0; offset_in = '0; sample_in = '0;
        do_reset();
        check("reset_ready", ready_out, 1);
        check("reset_done", done_out, 0);
        check("reset_div0", div0_out, 0);
        check_all("reset_coeffs", 0, -1, 0);

        for (int v = 0; v < 12; v++) begin
            if (vt[v].rst) do_reset();
            fill_samples(vt[v].fill, vt[v].spot, vt[v].spot_val);
            run_req(vt[v].err, vt[v].norm, vt[v].off, vt[v].leak, 1'b0, lat, d0, dones, rdy);
            check({vt[v].name, "_latency"}, lat, vt[v].lat);
            check({vt[v].name, "_div0"}, d0, vt[v].div0);
            check({vt[v].name, "_pulses"}, dones, 1);
            check({vt[v].name, "_ready_after"}, rdy, 1);
            check_all({vt[v].name, "_coeffs"}, vt[v].exp_all, vt[v].exp_k, vt[v].exp_kval);
        end

        // Standalone clear in IDLE, then an update proving accumulators restarted at zero.
        @(negedge clk_in); clear_in = 1'b1;
        @(negedge clk_in); clear_in = 1'b0;
        for (int k = 0; k < TAPS; k++) m_acc[k] = 0;
        check_all("clear_idle", 0, -1, 0);
        run_req(16384, 1, 0, 1'b0, 1'b0, lat, d0, dones, rdy);
        check_all("post_clear_update", 1, -1, 0);

        // clear_in asserted mid-request must be ignored.
        @(negedge clk_in);
        error_in = ERR_W'(16384); norm_in = NORM_W'(1); offset_in = '0; leak_en_in = 1'b0; valid_in = 1'b1;
        @(posedge clk_in);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
            clear_in = (i >= 2 && i <= 39);
            if (done_out && lat < 0) lat = i;
        end
        clear_in = 1'b0;
        model_update(16384, 1, 0, 1'b0, 1'b0);
        check("busy_clear_latency", lat, NORM_LAT);
        check_all("busy_clear_ignored", 2, -1, 0);

        // Reset asserted during DIV aborts the update.
        @(negedge clk_in);
        valid_in = 1'b1;
        @(posedge clk_in);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
        end
        rst_n_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_all("midreset_coeffs", 0, -1, 0);
        check("midreset_ready", ready_out, 1);
        check("midreset_done", done_out, 0);
        rst_n_in = 1'b1;
        for (int k = 0; k < TAPS; k++) m_acc[k] = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (done_out) dones++;
        end
        check("midreset_no_done", dones, 0);

        // valid_in held high: exactly one request per IDLE visit.
        error_in = ERR_W'(16384); norm_in = NORM_W'(1); offset_in = '0; leak_en_in = 1'b0;
        valid_in = 1'b1;
        acc_cnt = 0; dones = 0; first_acc = -1; second_acc = -1;
        for (int i = 0; i < 150; i++) begin
            if (done_out) dones++;
            if (valid_in && acc_cnt == 2) valid_in = 1'b0;
            if (valid_in && ready_out) begin
                if (acc_cnt == 0) first_acc = i; else second_acc = i;
                acc_cnt++;
            end
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        check("held_accepts", acc_cnt, 2);
        check("held_spacing", second_acc - first_acc, NORM_LAT + 1);
        check("held_dones", dones, 2);
        check_all("held_coeffs", 2, -1, 0);

        // Randomized requests against the model.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            mode = int'($urandom_range(0, 3));
            for (int j = 0; j < TAPS; j++)
                samp[j] = (r % 2 == 0) ? int'($urandom_range(0, 200)) - 100
                                       : int'($urandom_range(0, 65535)) - 32768;
            apply_samples();
            err  = int'($urandom_range(0, 65535)) - 32768;
            case (mode)
                0: norm = int'($urandom_range(1, 4));
                1: norm = int'($urandom_range(1, 1000000));
                2: norm = int'($urandom);
                default: norm = -int'($urandom_range(0, 5));
            endcase
            off  = int'($urandom_range(0, TAPS - 1));
            leak = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            run_req(err, norm, off, leak, clr, lat, d0, dones, rdy);
            check($sformatf("rand%0d_latency", r), lat, (norm <= 0) ? 1 : NORM_LAT);
            check($sformatf("rand%0d_div0", r), d0, (norm <= 0) ? 1 : 0);
            check_model($sformatf("rand%0d_coeffs", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
